// File: rtl/uart_tx_if.sv
// uart_tx_if -- handshake bundle between an upstream fifo and the UART transmitter.
//   tx_en      : permits the start of a new frame
//   fifo_empty : upstream fifo empty flag
//   fifo_data  : upstream fifo head word, valid while fifo_empty is 0
//   fifo_rd_en : one-cycle pop request issued by the transmitter
//   tx         : serial line, idle high
//   busy       : high from frame start until the last stop bit ends
// Modports: master = transmitter side, slave = fifo/controller side.
interface uart_tx_if #(
  parameter int WIDTH = 8
) ();
  logic             tx_en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rd_en;
  logic             tx;
  logic             busy;

  modport master (
    input  tx_en,
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en,
    output tx,
    output busy
  );

  modport slave (
    output tx_en,
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en,
    input  tx,
    input  busy
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx -- fifo-fed UART transmitter: start bit, WIDTH data bits LSB first,
// optional parity bit, STOP_BITS stop bits.
// Parameters: CLKS_PER_BIT (>=2), WIDTH, PARITY (0 none, 1 even, 2 odd),
//             STOP_BITS (1 or 2).
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : uart_tx_if master modport (tx_en, fifo_empty, fifo_data in;
//         fifo_rd_en, tx, busy out -- all outputs registered)
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WIDTH        = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       r_state;
  logic [CW-1:0]    r_baud;
  logic [BW-1:0]    r_bit;
  logic [WIDTH-1:0] r_shift;
  logic             r_par;
  logic             r_stop;
  logic             r_tx;
  logic             r_busy;
  logic             r_rd_en;

  logic             w_baud_done;
  logic             w_par_calc;
  logic [WIDTH-1:0] w_shift_next;

  assign w_baud_done  = (r_baud == BAUD_LAST);
  // Parity is computed from the captured word so the shift register can be
  // consumed during DATA; odd parity is simply the inverted even value.
  assign w_par_calc   = (^bus.fifo_data) ^ (PARITY == 2);
  assign w_shift_next = r_shift >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_stop  <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_rd_en <= 1'b0;
    end else begin
      // Pop request is a single-cycle pulse issued only on frame start.
      r_rd_en <= 1'b0;

      if (r_state == S_IDLE || w_baud_done) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.tx_en && !bus.fifo_empty) begin
            r_shift <= bus.fifo_data;
            r_par   <= w_par_calc;
            r_rd_en <= 1'b1;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_baud_done) begin
            r_state <= S_DATA;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
          end
        end

        S_DATA: begin
          if (w_baud_done) begin
            if (r_bit == BIT_LAST) begin
              if (PARITY != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
                r_stop  <= 1'b0;
              end
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= w_shift_next;
              r_tx    <= w_shift_next[0];
            end
          end
        end

        S_PARITY: begin
          if (w_baud_done) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
            r_stop  <= 1'b0;
          end
        end

        S_STOP: begin
          if (w_baud_done) begin
            if (r_stop == STOP_LAST) begin
              // Return to IDLE; the IDLE cycle is the only extra high cycle
              // before a back-to-back frame can start.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_stop <= r_stop + 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx         = r_tx;
  assign bus.busy       = r_busy;
  assign bus.fifo_rd_en = r_rd_en;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx with CLKS_PER_BIT=4, WIDTH=8.
// Four instances: 0 = no parity, 1 = even, 2 = odd, 3 = two stop bits.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [3:0] en_v;
  logic [3:0] empty_v;
  logic [7:0] data_v [4];
  wire  [3:0] tx_v;
  wire  [3:0] busy_v;
  wire  [3:0] rd_v;

  int n_checks;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_dut
      uart_tx_if #(.WIDTH(8)) bus ();

      assign bus.tx_en      = en_v[gi];
      assign bus.fifo_empty = empty_v[gi];
      assign bus.fifo_data  = data_v[gi];
      assign tx_v[gi]       = bus.tx;
      assign busy_v[gi]     = bus.busy;
      assign rd_v[gi]       = bus.fifo_rd_en;

      uart_tx #(
        .CLKS_PER_BIT(CPB),
        .WIDTH       (8),
        .PARITY      ((gi == 1) ? 1 : (gi == 2) ? 2 : 0),
        .STOP_BITS   ((gi == 3) ? 2 : 1)
      ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for bit period b of a frame.
  function automatic logic exp_bit(input int b, input logic [7:0] d,
                                   input int has_par, input logic par);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (has_par != 0 && b == 9) return par;
    return 1'b1;
  endfunction

  // Called at a negedge; sends one word on instance d and checks the whole frame.
  task automatic frame_check(input int d, input logic [7:0] data,
                             input int has_par, input logic par, input int stops);
    int nbits;
    nbits = 1 + 8 + has_par + stops;
    data_v[d]  = data;
    empty_v[d] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < nbits * CPB; i++) begin
      if (i == 0) begin
        // fifo pops; later data changes must not disturb the frame
        empty_v[d] = 1'b1;
        data_v[d]  = ~data;
      end
      chk($sformatf("d%0d_%02h_tx_c%0d", d, data, i), 32'(tx_v[d]),
          32'(exp_bit(i / CPB, data, has_par, par)));
      chk($sformatf("d%0d_%02h_busy_c%0d", d, data, i), 32'(busy_v[d]), 32'd1);
      chk($sformatf("d%0d_%02h_rd_c%0d", d, data, i), 32'(rd_v[d]), 32'(i == 0));
      @(negedge clk);
    end
    chk($sformatf("d%0d_%02h_end_busy", d, data), 32'(busy_v[d]), 32'd0);
    chk($sformatf("d%0d_%02h_end_tx", d, data), 32'(tx_v[d]), 32'd1);
    chk($sformatf("d%0d_%02h_end_rd", d, data), 32'(rd_v[d]), 32'd0);
    $display("frame d%0d data=%02h bits=%0d done", d, data, nbits);
  endtask

  initial begin
    int npulse, run, gap, p1, p2, bcnt, rcnt;
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b0;
    en_v     = 4'hF;
    empty_v  = 4'hF;
    for (int k = 0; k < 4; k++) data_v[k] = 8'h00;

    // Asynchronous reset before the first clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset_tx",   32'(tx_v),   32'hF);
    chk("reset_busy", 32'(busy_v), 32'h0);
    chk("reset_rd",   32'(rd_v),   32'h0);
    $display("reset applied before first clk edge");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_empty_tx", 32'(tx_v), 32'hF);
    chk("idle_empty_busy_rd", 32'({busy_v, rd_v}), 32'h0);

    // Single byte, no parity.
    frame_check(0, 8'hA5, 0, 1'b0, 1);
    // Even and odd parity on 0x07.
    frame_check(1, 8'h07, 1, 1'b1, 1);
    frame_check(2, 8'h07, 1, 1'b0, 1);
    // Two stop bits on 0x00: 36 low cycles then 8 high.
    frame_check(3, 8'h00, 0, 1'b0, 2);

    // Back-to-back frames 0x55 then 0xAA.
    data_v[0] = 8'h55;
    empty_v[0] = 1'b0;
    npulse = 0; run = 0; gap = -1; p1 = 0; p2 = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (rd_v[0]) begin
        npulse++;
        if (npulse == 1) begin
          p1 = c;
          data_v[0] = 8'hAA;
        end else begin
          p2 = c;
          empty_v[0] = 1'b1;
        end
      end
      if (tx_v[0]) run++;
      else begin
        if (rd_v[0] && npulse == 2) gap = run;
        run = 0;
      end
      if (npulse == 2 && !busy_v[0]) break;
    end
    chk("b2b_pulses", 32'(npulse), 32'd2);
    chk("b2b_spacing", 32'(p2 - p1), 32'd41);
    chk("b2b_gap_high", 32'(gap), 32'd5);
    $display("back-to-back pulses=%0d spacing=%0d gap=%0d", npulse, p2 - p1, gap);

    // Flow control: tx_en low holds IDLE even with data available.
    en_v[0] = 1'b0;
    data_v[0] = 8'h3C;
    empty_v[0] = 1'b0;
    rcnt = 0; bcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rd_v[0]) rcnt++;
      if (!tx_v[0] || busy_v[0]) bcnt++;
    end
    chk("flow_hold_pulses", 32'(rcnt), 32'd0);
    chk("flow_hold_active", 32'(bcnt), 32'd0);
    en_v[0] = 1'b1;
    @(negedge clk);
    chk("flow_start_rd", 32'(rd_v[0]), 32'd1);
    en_v[0] = 1'b0;
    rcnt = 0; bcnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (rd_v[0]) rcnt++;
      if (busy_v[0]) bcnt++;
      @(negedge clk);
    end
    chk("flow_busy_cycles", 32'(bcnt), 32'd40);
    chk("flow_pulses", 32'(rcnt), 32'd1);
    chk("flow_end_tx", 32'(tx_v[0]), 32'd1);
    $display("flow control busy=%0d pulses=%0d", bcnt, rcnt);

    // Reset in DATA bit 3 aborts the frame without a clock edge.
    empty_v[0] = 1'b1;
    en_v[0] = 1'b1;
    @(negedge clk);
    data_v[0] = 8'h00;
    empty_v[0] = 1'b0;
    @(negedge clk);
    chk("rstmid_start_rd", 32'(rd_v[0]), 32'd1);
    empty_v[0] = 1'b1;
    repeat (17) @(negedge clk);
    chk("rstmid_pre_tx", 32'(tx_v[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_tx", 32'(tx_v[0]), 32'd1);
    chk("rstmid_busy", 32'(busy_v[0]), 32'd0);
    chk("rstmid_rd", 32'(rd_v[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rcnt = 0; bcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd_v[0]) rcnt++;
      if (busy_v[0] || !tx_v[0]) bcnt++;
    end
    chk("rstmid_after_pulses", 32'(rcnt), 32'd0);
    chk("rstmid_after_active", 32'(bcnt), 32'd0);
    $display("reset mid-frame pulses_after=%0d", rcnt);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clock cycles per serial bit (115200 baud at 100 MHz); legal range is 2 or more.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving data bits per frame.
REQ-003 The block SHALL have parameter PARITY, default 0, where 0 = none, 1 = even, 2 = odd.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits; legal values are 1 and 2.
REQ-005 Port clk: input, 1 bit; the single clock; all state changes on its rising edge.
REQ-006 Port rst: input, 1 bit; reset, asynchronous and active-high.
REQ-007 Port tx_en: input, 1 bit; permits the start of a new frame; a frame in progress always completes.
REQ-008 Port fifo_empty: input, 1 bit; empty flag of the upstream fifo.
REQ-009 Port fifo_data: input, WIDTH bits; the upstream fifo head word, valid combinationally whenever fifo_empty is 0.
REQ-010 Port fifo_rd_en: output, 1 bit; registered pop request; the fifo pops on its rising edge.
REQ-011 Port tx: output, 1 bit; registered serial line, idle high.
REQ-012 Port busy: output, 1 bit; registered; 1 from frame start until the last stop bit ends.

Function
REQ-013 States SHALL be IDLE, START, DATA, PARITY and STOP, encoded in a registered state machine.
REQ-014 In IDLE, on a rising clk edge with tx_en=1 and fifo_empty=0, the block SHALL:
- capture fifo_data into a shift register;
- set fifo_rd_en=1, tx=0 and busy=1;
- enter START with the baud counter at 0.
REQ-015 fifo_rd_en SHALL be high for exactly one cycle per frame; it is guaranteed low for at least CLKS_PER_BIT-1 cycles before any next pulse, so every pulse is a distinct rising edge.
REQ-016 The baud counter SHALL count 0..CLKS_PER_BIT-1, with width clog2(CLKS_PER_BIT); each bit period SHALL last exactly CLKS_PER_BIT cycles.
REQ-017 START SHALL drive tx=0 for one bit period, then enter DATA.
REQ-018 DATA SHALL drive WIDTH bits LSB first, one bit period each, with a bit index 0..WIDTH-1.
- After bit WIDTH-1, go to PARITY if PARITY != 0, else go to STOP.
REQ-019 PARITY SHALL drive one bit period of:
- XOR of the data bits (even parity);
- or its inverse (odd parity);
- then enter STOP.
REQ-020 STOP SHALL drive tx=1 for STOP_BITS bit periods, then return to IDLE with busy=0.
REQ-021 Back-to-back frames: the IDLE cycle after STOP SHALL be the only extra high cycle, so the gap is STOP_BITS*CLKS_PER_BIT+1 cycles of tx=1.
REQ-022 Frame length from the start edge to the return to IDLE SHALL be (1+WIDTH+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-023 A change of fifo_data or fifo_empty after capture SHALL NOT affect the frame in progress.
REQ-024 tx_en=0 SHALL only hold the block in IDLE and SHALL NOT truncate an active frame.
REQ-025 fifo_empty=1 in IDLE SHALL keep tx=1, busy=0 and fifo_rd_en=0 indefinitely.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force:
- state=IDLE, tx=1, busy=0, fifo_rd_en=0;
- baud counter, bit index and shift register to 0.
REQ-027 Reset mid-frame SHALL abort the frame; the popped byte is discarded and SHALL NOT be re-requested.
REQ-028 After rst deasserts, the first frame SHALL start no earlier than the first rising clk edge with rst=0.

Verification (bench uses CLKS_PER_BIT=4, WIDTH=8)
REQ-029 Single byte, PARITY=0: fifo_data=0xA5 with fifo_empty=0 for one pop -> one fifo_rd_en pulse; tx sequence 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; busy high 40 cycles.
REQ-030 Parity: PARITY=1 with 0x07 -> parity bit 1; PARITY=2 with 0x07 -> parity bit 0; frame 44 cycles.
REQ-031 Back-to-back: fifo holding 0x55 then 0xAA -> exactly 2 fifo_rd_en pulses 41 cycles apart; 5 high cycles between the frames.
REQ-032 Flow control: tx_en=0 with fifo_empty=0 -> no pulse and tx=1; tx_en deasserted mid-frame -> frame completes, no next frame starts.
REQ-033 Reset mid-frame: rst asserted in DATA bit 3 -> tx=1 and busy=0 with no clk edge; after release with fifo_empty=1, no pulse occurs.
REQ-034 STOP_BITS=2: byte 0x00 -> tx low 36 cycles, then high 8 cycles before busy falls.
